ssd_scan_driver: RTL
====================

# ssd_scan_driver

Parametrised, time-multiplexed seven-segment display driver for N common-anode digits. It replaces hand-written per-design anode/cathode scan logic in our board tops. It adds double-buffered loading with tear-free commit at frame boundaries, per-digit blanking, decimal points and blink, leading-zero suppression, and PWM brightness. It sits between design-level display data and the board's An*/Ca..Cg/Dp pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV_BITS, 18, each digit slot lasts 2^SCAN_DIV_BITS clocks (≥ PWM_BITS)
- PWM_BITS, 4, brightness resolution
- BLINK_DIV_BITS, 26, blink period 2^BLINK_DIV_BITS clocks, 50% duty

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit 0 (rightmost) = [3:0]
- dp_in  in  NUM_DIGITS  1 = decimal point lit
- blank_in  in  NUM_DIGITS  1 = digit forced dark
- blink_in  in  NUM_DIGITS  1 = digit flashes
- lz_blank  in  1  leading-zero suppression enable
- brightness  in  PWM_BITS  duty select, sampled live (not buffered)
- load  in  1  capture digits_in/dp_in/blank_in/blink_in/lz_blank into pending buffer
- An  out  NUM_DIGITS  anodes, active-low
- Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
- update_pending  out  1  pending buffer holds uncommitted data
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- Free-running prescaler `pre` (SCAN_DIV_BITS wide). When `pre` is all-ones, the digit index `idx` advances.
- Scan order: digit NUM_DIGITS-1 first, descending to 0, then wrap to NUM_DIGITS-1.
- Frame boundary: the advance from idx=0 to NUM_DIGITS-1.
- Buffers: pending (written by load) and active (drives the display).
  - load=1 captures all buffered inputs into pending and sets update_pending.
  - At a frame boundary with update_pending=1: active ← pending, update_pending ← 0.
  - If load coincides with the boundary, inputs are committed directly to active and update_pending ends at 0.
  - Repeated loads within a frame: the last one wins.
- Digit `d` is dark if any of the following hold:
  - active blank[d];
  - active blink[d] and blink phase = 1 (MSB of free-running blink counter);
  - leading-zero suppressed: active lz_blank, d ≠ 0, and all active digits from NUM_DIGITS-1 down to d are 0 with dp=0;
  - PWM off.
- PWM: pwm_cnt = pre[SCAN_DIV_BITS-1 -: PWM_BITS]. Lit iff pwm_cnt ≤ brightness, giving duty (brightness+1)/2^PWM_BITS. Max brightness = always on.
- When digit idx is lit: An has only bit idx low. Cathodes = hex encoding (abcdefg active-low) concatenated with ~dp.
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Dark digit: An all ones, Cathodes 8'hFF.

## Timing
- Reset (async):
  - An = all ones, Cathodes = 8'hFF, frame_tick = 0, update_pending = 0.
  - pre = 0, blink counter = 0, idx = NUM_DIGITS-1.
  - Active and pending: digits 0, dp 0, blink 0, lz 0, blank all ones, so the display stays dark until the first load commits.
- Reset asserted mid-frame behaves identically and discards pending data.
- An/Cathodes are registered and reflect idx, active data and PWM one cycle after they change.
- idx updates on the edge where pre wraps to 0. The first cycle of the new slot shows the new An.
- frame_tick is registered and high for exactly one cycle, on the same edge that loads idx=NUM_DIGITS-1 and commits active. The first display cycle of the new frame is the cycle after.
- Frame length = NUM_DIGITS·2^SCAN_DIV_BITS clocks.
- Worst-case load→display latency = one frame + 2 cycles.
- No load-to-load restriction; load may be held high (pending re-captures every cycle).

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV_BITS=4, PWM_BITS=2, BLINK_DIV_BITS=8.
- **Reset:** Reset pulse, no load for 3 frames → An=4'b1111, Cathodes=8'hFF throughout; frame_tick every 64 cycles.
- **Load and scan:**
  - Setup: load digits_in=16'h12AF, dp_in=4'b0010, brightness=3.
  - After next frame_tick+1: An sequence 0111,1011,1101,1110, each for 16 cycles.
  - Cathodes sequence 10011111, 00100101, 00010000, 01110001.
- **Tear-free update:** Load 16'h1111, then load 16'h2222 mid-frame (idx=2) → current frame shows only 1s; next frame shows only 2s. update_pending clears on the frame_tick edge.
- **Boundary coincidence:** load 16'h3333 on exactly the frame_tick edge → that frame shows 3s and update_pending=0 afterwards.
- **Leading zeros:** load 16'h0050 with lz_blank=1 → digits 3,2 dark; digit1=5; digit0=0 shown. With dp_in=4'b1000, digit 3 is shown as 0 with Dp low.
- **PWM and blink:**
  - brightness=1 → each lit slot's An active for 8 of 16 cycles.
  - blink_in=4'b0001 → digit 0 dark during the 128-cycle intervals where blink MSB=1; other digits unaffected.

Source files
------------

// File: rtl/ssd_scan_driver_if.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver_if
//
// Groups the design-facing side of the seven-segment scan driver: the display
// data to be loaded, the load strobe, live brightness and the two status
// outputs. The board-facing An/Cathodes pins stay plain ports on the driver.
//
// Handshake: load is a single-cycle qualifier with no ready. Every cycle it is
// high, digits_in/dp_in/blank_in/blink_in/lz_blank are captured; the driver
// never stalls. update_pending and frame_tick are status only.
//
// Signals:
//   digits_in      hex nibble per digit, digit 0 (rightmost) in [3:0]
//   dp_in          1 = decimal point lit
//   blank_in       1 = digit forced dark
//   blink_in       1 = digit flashes
//   lz_blank       leading-zero suppression enable
//   brightness     PWM duty select, sampled live
//   load           capture the buffered inputs into the pending buffer
//   update_pending pending buffer holds data not yet on the display
//   frame_tick     one-cycle pulse at each frame boundary
//
// Modports: master = data source, slave = ssd_scan_driver.
// ----------------------------------------------------------------------------
interface ssd_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int PWM_BITS   = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [NUM_DIGITS-1:0]   blink_in;
   logic                    lz_blank;
   logic [PWM_BITS-1:0]     brightness;
   logic                    load;
   logic                    update_pending;
   logic                    frame_tick;

   modport master (
      output digits_in, dp_in, blank_in, blink_in, lz_blank, brightness, load,
      input  update_pending, frame_tick
   );

   modport slave (
      input  digits_in, dp_in, blank_in, blink_in, lz_blank, brightness, load,
      output update_pending, frame_tick
   );
endinterface

// File: rtl/ssd_scan_driver.sv
// ----------------------------------------------------------------------------
// ssd_scan_driver
//
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Display data is double buffered: load writes a pending buffer, which is
// copied to the active buffer only at a frame boundary so a frame never shows
// a mix of old and new data. Each digit can be blanked, blinked, carry a
// decimal point, or be hidden as a leading zero; a PWM window inside each
// digit slot sets brightness.
//
// Ports:
//   Clk       system clock
//   Reset     asynchronous, active-high reset
//   bus       ssd_scan_driver_if.slave (data in, load, brightness, status out)
//   An        anodes, active-low, one bit per digit
//   Cathodes  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
//
// Scan: digit NUM_DIGITS-1 first, descending to 0, each slot lasting
// 2^SCAN_DIV_BITS clocks. The wrap from digit 0 back to the top digit is the
// frame boundary, where frame_tick pulses and pending data is committed.
// An/Cathodes are registered, so they lag the scan state by one cycle.
// ----------------------------------------------------------------------------
module ssd_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV_BITS  = 18,
   parameter int PWM_BITS       = 4,
   parameter int BLINK_DIV_BITS = 26
) (
   input  logic                  Clk,
   input  logic                  Reset,
   ssd_scan_driver_if.slave      bus,
   output logic [NUM_DIGITS-1:0] An,
   output logic [7:0]            Cathodes
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   // Everything that load captures, kept together so pending and active
   // buffers always move as one unit.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   blank;
      logic [NUM_DIGITS-1:0]   blink;
      logic                    lz;
   } frame_buf_t;

   // All digits blanked so the display stays dark until the first commit.
   localparam frame_buf_t RESET_BUF = '{
      digits: '0,
      dp:     '0,
      blank:  '1,
      blink:  '0,
      lz:     1'b0
   };

   // ------------------------------------------------------------------------
   // Scan timing
   // ------------------------------------------------------------------------
   logic [SCAN_DIV_BITS-1:0]  pre;
   logic [BLINK_DIV_BITS-1:0] blink_cnt;
   logic [IDX_W-1:0]          idx;
   logic                      frame_tick_r;
   logic                      slot_end;
   logic                      frame_end;

   assign slot_end  = &pre;
   assign frame_end = slot_end && (idx == '0);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pre          <= '0;
         blink_cnt    <= '0;
         idx          <= IDX_W'(NUM_DIGITS - 1);
         frame_tick_r <= 1'b0;
      end else begin
         pre          <= pre + 1'b1;
         blink_cnt    <= blink_cnt + 1'b1;
         frame_tick_r <= frame_end;
         if (slot_end) begin
            idx <= (idx == '0) ? IDX_W'(NUM_DIGITS - 1) : idx - 1'b1;
         end
      end
   end

   assign bus.frame_tick = frame_tick_r;

   // ------------------------------------------------------------------------
   // Double buffering
   // ------------------------------------------------------------------------
   frame_buf_t in_buf;
   frame_buf_t pend_buf;
   frame_buf_t act_buf;
   logic       pend_valid;

   always_comb begin
      in_buf        = RESET_BUF;
      in_buf.digits = bus.digits_in;
      in_buf.dp     = bus.dp_in;
      in_buf.blank  = bus.blank_in;
      in_buf.blink  = bus.blink_in;
      in_buf.lz     = bus.lz_blank;
   end

   // A load landing on the boundary edge bypasses pending and goes straight
   // to active; otherwise pending data waits for the next boundary.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pend_buf   <= RESET_BUF;
         act_buf    <= RESET_BUF;
         pend_valid <= 1'b0;
      end else begin
         if (bus.load) begin
            pend_buf <= in_buf;
         end
         if (frame_end && bus.load) begin
            act_buf    <= in_buf;
            pend_valid <= 1'b0;
         end else if (frame_end && pend_valid) begin
            act_buf    <= pend_buf;
            pend_valid <= 1'b0;
         end else if (bus.load) begin
            pend_valid <= 1'b1;
         end
      end
   end

   assign bus.update_pending = pend_valid;

   // ------------------------------------------------------------------------
   // Leading-zero suppression
   // ------------------------------------------------------------------------
   // lz_run stays high while every digit from the top down is 0 with its dp
   // off. Digit 0 is never suppressed so a zero value still shows "0".
   logic [NUM_DIGITS-1:0] lz_dark;
   logic                  lz_run;

   always_comb begin
      lz_dark = '0;
      lz_run  = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
         lz_run     = lz_run && (act_buf.digits[4*d +: 4] == 4'h0) && !act_buf.dp[d];
         lz_dark[d] = act_buf.lz && lz_run;
      end
   end

   // ------------------------------------------------------------------------
   // Current digit selection and display decode
   // ------------------------------------------------------------------------
   logic [3:0]              cur_digit;
   logic                    cur_dp;
   logic                    cur_blank;
   logic                    cur_blink;
   logic                    cur_lz;
   logic [PWM_BITS-1:0]     pwm_cnt;
   logic                    pwm_on;
   logic                    blink_phase;
   logic                    dark;
   logic [NUM_DIGITS-1:0]   next_an;
   logic [7:0]              next_cath;

   always_comb begin
      cur_digit = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b1;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IDX_W'(d)) begin
            cur_digit = act_buf.digits[4*d +: 4];
            cur_dp    = act_buf.dp[d];
            cur_blank = act_buf.blank[d];
            cur_blink = act_buf.blink[d];
            cur_lz    = lz_dark[d];
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] v);
      // abcdefg, active-low
      case (v)
         4'h0:    seg7 = 7'b0000001;
         4'h1:    seg7 = 7'b1001111;
         4'h2:    seg7 = 7'b0010010;
         4'h3:    seg7 = 7'b0000110;
         4'h4:    seg7 = 7'b1001100;
         4'h5:    seg7 = 7'b0100100;
         4'h6:    seg7 = 7'b0100000;
         4'h7:    seg7 = 7'b0001111;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0000100;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b1100000;
         4'hC:    seg7 = 7'b0110001;
         4'hD:    seg7 = 7'b1000010;
         4'hE:    seg7 = 7'b0110000;
         default: seg7 = 7'b0111000;
      endcase
   endfunction

   // The PWM window is the top bits of the slot prescaler, so the lit part
   // of every slot starts at the slot's first cycle; maximum brightness keeps
   // the comparison always true.
   assign pwm_cnt     = pre[SCAN_DIV_BITS-1 -: PWM_BITS];
   assign pwm_on      = (pwm_cnt <= bus.brightness);
   assign blink_phase = blink_cnt[BLINK_DIV_BITS-1];

   always_comb begin
      dark      = cur_blank || (cur_blink && blink_phase) || cur_lz || !pwm_on;
      next_an   = '1;
      next_cath = 8'hFF;
      if (!dark) begin
         next_an   = ~(NUM_DIGITS'(1) << idx);
         next_cath = {seg7(cur_digit), ~cur_dp};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         An       <= '1;
         Cathodes <= 8'hFF;
      end else begin
         An       <= next_an;
         Cathodes <= next_cath;
      end
   end

endmodule
